mul_share_ctrl: RTL

Round-robin scheduler that shares one serial shift-add 16x16 unsigned multiplier among up to NREQ requesters. It grants one requester at a time, captures that requester's operands, runs the multiplier for WIDTH cycles, and returns the product tagged with the requester index. It sits between the requesting blocks and the multiplier datapath, and it is the only block that starts the multiplier.

---
 rtl/mul_share_pkg.sv | 14 +
 rtl/serial_mul_core.sv | 46 ++++
 rtl/mul_share_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and default sizes for the shared serial multiplier scheduler.
package mul_share_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    GAP
  } state_t;

endpackage

// File: rtl/serial_mul_core.sv
// Serial shift-add unsigned multiplier: one operand bit per step, WIDTH steps per product.
module serial_mul_core
  import mul_share_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last_step,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   areg;
  logic [WIDTH-1:0]   breg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // The accumulator is double width, so the partial sums never overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg <= '0;
      breg <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      areg <= a;
      breg <= b;
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      if (areg[cnt])
        acc <= acc + ({{WIDTH{1'b0}}, breg} << cnt);
      cnt <= last_step ? '0 : cnt + CW'(1);
    end
  end

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign product   = acc;

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one serial multiplier among NREQ requesters.
// Optional MUL_SHARE_ZERO_SKIP_EN: zero operands bypass RUN and return 0 right away.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [2*WIDTH-1:0]    y_out,
  output logic                  y_valid,
  output logic [IDW-1:0]        y_id,
  output logic                  busy
);

  state_t             state;
  logic [IDW-1:0]     last_gnt;
  logic [IDW-1:0]     win_idx;
  logic [IDW-1:0]     cand;
  logic               win_found;
  logic [WIDTH-1:0]   a_slice [NREQ];
  logic [WIDTH-1:0]   b_slice [NREQ];
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic               zero_op;
  logic               load;
  logic               step;
  logic               last_step;
  logic [2*WIDTH-1:0] product;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_slice[i] = a_in[i*WIDTH +: WIDTH];
    assign b_slice[i] = b_in[i*WIDTH +: WIDTH];
  end

  // Search starts just past the last winner so every requester gets its turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_gnt) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign a_sel = a_slice[win_idx];
  assign b_sel = b_slice[win_idx];

`ifdef MUL_SHARE_ZERO_SKIP_EN
  assign zero_op = (a_sel == '0) || (b_sel == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign load = (state == IDLE) && win_found;
  assign step = (state == RUN);

  serial_mul_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a        (a_sel),
    .b        (b_sel),
    .last_step(last_step),
    .product  (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= IDW'(NREQ - 1);
      gnt      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      y_id     <= '0;
      busy     <= 1'b0;
    end else begin
      gnt     <= '0;
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt      <= NREQ'(1) << win_idx;
            last_gnt <= win_idx;
            busy     <= 1'b1;
            state    <= zero_op ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_step)
            state <= DONE;
        end
        DONE: begin
          y_out   <= product;
          y_id    <= last_gnt;
          y_valid <= 1'b1;
          state   <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
